// File: rtl/ballot_pkg.sv
// Shared types for the ballot controller: FSM state encoding and the default candidate count.
package ballot_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        IDLE    = 3'd1,
        ARMED   = 3'd2,
        CAST    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int DEF_NUM_CAND = 4;

endpackage

// File: rtl/btn_conditioner.sv
// Per-bit 2-FF synchronizer followed by a debouncer; clean follows the synchronized level
// only after DEB_CYC identical samples (2 sync cycles + DEB_CYC cycles to settle), no backpressure.
module btn_conditioner #(
    parameter int WIDTH   = 1,
    parameter int DEB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [DW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= '0;
            sync  <= '0;
            clean <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            // Count consecutive samples that disagree with the accepted level; any agreement restarts the run.
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] != clean[i]) begin
                    if (cnt[i] == DW'(DEB_CYC - 1)) begin
                        clean[i] <= sync[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/ballot_controller.sv
// Voting-booth controller: conditions buttons, arms per voter, emits a one-hot vote strobe and saturating tallies.
// Strobe appears the cycle after a single clean press is seen in ARMED; no backpressure on vote_en.
module ballot_controller
    import ballot_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int DEB_CYC     = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                session_open,
    input  logic                voter_auth,
    input  logic [NUM_CAND-1:0] button,
    output logic [NUM_CAND-1:0] vote_en,
    output logic                ready_led,
    output logic                busy,
    output logic                multi_err,
    output logic [CNT_W-1:0]    voters,
    output logic [CNT_W-1:0]    abstains
);

    localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Assert asynchronously, release two clocks later so every flop leaves reset on the same edge.
    logic [1:0] rst_pipe;
    logic       rst_core;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_core = rst_pipe[1];

    logic [NUM_CAND-1:0] clean;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
        btn_conditioner #(
            .WIDTH   (1),
            .DEB_CYC (DEB_CYC)
        ) u_cond (
            .clk   (clk),
            .rst   (rst_core),
            .raw   (button[g]),
            .clean (clean[g])
        );
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, sel_idx;
    logic [TW-1:0]    timer;
    logic             any_press, single_press, multi_cond, multi_prev;
    logic             do_cast, do_abstain;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (clean[i]) sel_idx = IDX_W'(i);
        end
    end

    assign any_press    = |clean;
    assign single_press = any_press && ((clean & (clean - 1'b1)) == '0);
    assign multi_cond   = (state == ARMED) && session_open && any_press && !single_press;

    always_comb begin
        state_nxt  = state;
        do_cast    = 1'b0;
        do_abstain = 1'b0;
        case (state)
            CLOSED: begin
                if (session_open) state_nxt = IDLE;
            end
            IDLE: begin
                if (!session_open)                 state_nxt = CLOSED;
                else if (voter_auth && !any_press) state_nxt = ARMED;
            end
            ARMED: begin
                // Session close beats a press; a press beats the timeout.
                if (!session_open) begin
                    state_nxt = CLOSED;
                end else if (single_press) begin
                    state_nxt = CAST;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    state_nxt  = IDLE;
                    do_abstain = 1'b1;
                end
            end
            CAST: begin
                do_cast   = 1'b1;
                state_nxt = session_open ? RELEASE : CLOSED;
            end
            RELEASE: begin
                if (!any_press) state_nxt = IDLE;
            end
            default: state_nxt = CLOSED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_core) begin
        if (!rst_core) begin
            state      <= CLOSED;
            idx        <= '0;
            timer      <= '0;
            multi_prev <= 1'b0;
            multi_err  <= 1'b0;
            voters     <= '0;
            abstains   <= '0;
        end else begin
            state      <= state_nxt;
            multi_prev <= multi_cond;
            multi_err  <= multi_cond && !multi_prev;
            if (state == ARMED && state_nxt == CAST) idx <= sel_idx;
            if (state == ARMED && state_nxt == ARMED) timer <= timer + 1'b1;
            else                                      timer <= '0;
            if (do_cast && voters != '1)       voters   <= voters + 1'b1;
            if (do_abstain && abstains != '1)  abstains <= abstains + 1'b1;
        end
    end

    always_comb begin
        vote_en = '0;
        if (state == CAST) vote_en[idx] = 1'b1;
    end

    assign ready_led = (state == ARMED);
    assign busy      = (state == ARMED) || (state == CAST) || (state == RELEASE);

endmodule

// File: tb/tb_ballot_controller.sv
// Scoreboard bench for ballot_controller: stimulus queues expected strobe/multi events, a monitor pops and compares.
module tb_ballot_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       session_open;
    logic       voter_auth;
    logic [3:0] button;
    logic [3:0] vote_en;
    logic       ready_led, busy, multi_err;
    logic [1:0] voters, abstains;

    int checks   = 0;
    int failures = 0;

    // Event encoding: {multi_err, vote_en}
    logic [4:0] exp_q[$];
    logic [4:0] mon_got, mon_exp;

    always #5 clk = ~clk;

    ballot_controller #(
        .NUM_CAND    (4),
        .DEB_CYC     (4),
        .TIMEOUT_CYC (64),
        .CNT_W       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .session_open (session_open),
        .voter_auth   (voter_auth),
        .button       (button),
        .vote_en      (vote_en),
        .ready_led    (ready_led),
        .busy         (busy),
        .multi_err    (multi_err),
        .voters       (voters),
        .abstains     (abstains)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (vote_en != 4'b0000 || multi_err) begin
            mon_got = {multi_err, vote_en};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got %b expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic auth_pulse();
        voter_auth = 1'b1;
        tick(1);
        voter_auth = 1'b0;
    endtask

    task automatic do_vote(input int i);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        auth_pulse();
        exp_q.push_back({1'b0, oh});
        button = oh;
        tick(10);
        button = 4'b0000;
        tick(8);
    endtask

    initial begin
        bit seen;
        rst          = 1'b0;
        session_open = 1'b0;
        voter_auth   = 1'b0;
        button       = 4'b0000;
        tick(3);
        check("rst_vote_en",  32'(vote_en),   0);
        check("rst_ready",    32'(ready_led), 0);
        check("rst_busy",     32'(busy),      0);
        check("rst_multi",    32'(multi_err), 0);
        check("rst_voters",   32'(voters),    0);
        check("rst_abstains", 32'(abstains),  0);
        rst = 1'b1;
        tick(3);

        // Single held press: one strobe, auth while busy ignored, nothing more until release
        session_open = 1'b1;
        tick(2);
        check("idle_ready", 32'(ready_led), 0);
        auth_pulse();
        check("armed_ready", 32'(ready_led), 1);
        check("armed_busy",  32'(busy),      1);
        exp_q.push_back(5'b0_0100);
        button = 4'b0100;
        tick(10);
        check("held_voters", 32'(voters),    1);
        check("held_busy",   32'(busy),      1);
        check("held_ready",  32'(ready_led), 0);
        auth_pulse();
        tick(10);
        check("busy_auth_voters", 32'(voters), 1);
        check("busy_auth_ready",  32'(ready_led), 0);
        button = 4'b0000;
        tick(8);
        check("released_busy", 32'(busy), 0);

        // Simultaneous press rejected, then a single press on button 3
        auth_pulse();
        exp_q.push_back(5'b1_0000);
        button = 4'b0011;
        tick(10);
        check("multi_still_armed", 32'(ready_led), 1);
        check("multi_voters",      32'(voters),    1);
        button = 4'b0000;
        tick(8);
        exp_q.push_back(5'b0_1000);
        button = 4'b1000;
        tick(10);
        check("after_multi_voters", 32'(voters), 2);
        button = 4'b0000;
        tick(8);

        // Timeout boundary: still armed at timer 63, abstain on the next edge
        auth_pulse();
        tick(63);
        check("timeout_edge_ready", 32'(ready_led), 1);
        tick(1);
        check("timeout_ready",    32'(ready_led), 0);
        check("timeout_busy",     32'(busy),      0);
        check("timeout_abstains", 32'(abstains),  1);

        // Short glitch casts nothing; closing the session in ARMED leaves counters alone
        auth_pulse();
        button = 4'b0010;
        tick(2);
        button = 4'b0000;
        tick(10);
        check("glitch_voters", 32'(voters),    2);
        check("glitch_armed",  32'(ready_led), 1);
        session_open = 1'b0;
        tick(1);
        check("close_busy",     32'(busy),     0);
        check("close_voters",   32'(voters),   2);
        check("close_abstains", 32'(abstains), 1);
        auth_pulse();
        check("closed_auth_ready", 32'(ready_led), 0);

        // Reset while the strobe is up clears everything at once
        session_open = 1'b1;
        tick(2);
        auth_pulse();
        exp_q.push_back(5'b0_0001);
        button = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #2;
            if (vote_en != 4'b0000) seen = 1'b1;
        end
        check("cast_reached", 32'(seen), 1);
        rst = 1'b0;
        #1;
        check("midcast_vote_en",  32'(vote_en),   0);
        check("midcast_busy",     32'(busy),      0);
        check("midcast_ready",    32'(ready_led), 0);
        check("midcast_voters",   32'(voters),    0);
        check("midcast_abstains", 32'(abstains),  0);
        @(negedge clk);
        button = 4'b0000;
        tick(2);
        rst = 1'b1;
        tick(5);

        // Saturation of both 2-bit tallies
        for (int i = 0; i < 4; i++) do_vote(i);
        check("sat_voters", 32'(voters), 3);
        for (int i = 0; i < 4; i++) begin
            auth_pulse();
            tick(66);
        end
        check("sat_abstains", 32'(abstains), 3);
        check("sat_voters_hold", 32'(voters), 3);

        tick(4);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
